// File: rtl/lzc_norm_pkg.sv
// Shared types and widths for the leading-zero normalize sequencer.
package lzc_norm_pkg;

  // Sequencer states: upper half into the LZC, check it, optionally the lower half, hold result.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    CHK  = 3'd2,
    LO   = 3'd3,
    OUT  = 3'd4
  } state_e;

  localparam int HALF_W  = 16;
  localparam int SHIFT_W = 6;

endpackage : lzc_norm_pkg

// File: rtl/sixteen_bit_lzc.sv
// Registered 16-bit leading-zero counter, one cycle of latency.
// An all-zero input reports 15, the same as an input of 0x0001, so callers
// must detect zero separately.
module sixteen_bit_lzc (
  input  logic        clk,
  input  logic [15:0] array,
  output logic [3:0]  value
);

  logic [3:0] count;

  // Priority scan: the highest set bit wins because later iterations overwrite.
  always_comb begin
    // NOTE: default assigned before the loop so every path writes count and no latch is inferred.
    count = 4'd15;
    for (int i = 0; i < 16; i++) begin
      if (array[i]) count = 4'(15 - i);
    end
  end

  // Capture the count; the consumer only reads it one cycle after driving array.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values; this register
    // has no reset because its content is always overwritten before it is used.
    value <= count;
  end

endmodule : sixteen_bit_lzc

// File: rtl/lzc_normalize_sequencer.sv
// Normalizes a 32-bit mantissa by time-sharing one 16-bit LZC across both
// halves. Upper half first; the lower half is only examined when the upper
// half is zero. Zero detection uses OR-reductions, never the LZC output.
module lzc_normalize_sequencer
  import lzc_norm_pkg::*;
#(
  parameter int unsigned ZERO_SHIFT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_shift,
  output logic        out_zero
);

  localparam logic [SHIFT_W-1:0] ZERO_SHIFT_C = SHIFT_W'(ZERO_SHIFT);
  localparam logic [SHIFT_W-1:0] HALF_SHIFT_C = SHIFT_W'(HALF_W);

  state_e               state_q;
  logic [31:0]          data_q;
  logic                 out_valid_q;
  logic [31:0]          out_data_q;
  logic [SHIFT_W-1:0]   out_shift_q;
  logic                 out_zero_q;

  logic [HALF_W-1:0]    lzc_array;
  logic [3:0]           lzc_value;
  logic                 hi_nz;
  logic                 lo_nz;
  logic [SHIFT_W-1:0]   shift_d;
  logic [31:0]          shifted_d;

  sixteen_bit_lzc u_lzc (
    .clk   (clk),
    .array (lzc_array),
    .value (lzc_value)
  );

  // LZC input mux, half-zero detect and the inline barrel shifter.
  always_comb begin
    lzc_array = (state_q == HI) ? data_q[31:16] : data_q[15:0];
    hi_nz     = |data_q[31:16];
    lo_nz     = |data_q[15:0];
    // In LO the count refers to the lower half, so it is offset by the upper half width.
    shift_d   = (state_q == LO) ? (HALF_SHIFT_C + SHIFT_W'(lzc_value))
                                : SHIFT_W'(lzc_value);
    // Bits pushed beyond bit 31 are leading zeros, so truncation loses nothing.
    shifted_d = data_q << shift_d;
  end

  // Sequencer FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_shift_q <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            state_q <= HI;
          end
        end
        HI: begin
          state_q <= CHK;
        end
        CHK: begin
          if (hi_nz) begin
            out_shift_q <= shift_d;
            out_data_q  <= shifted_d;
            out_zero_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            state_q <= LO;
          end
        end
        LO: begin
          if (lo_nz) begin
            out_shift_q <= shift_d;
            out_data_q  <= shifted_d;
            out_zero_q  <= 1'b0;
          end else begin
            out_shift_q <= ZERO_SHIFT_C;
            out_data_q  <= '0;
            out_zero_q  <= 1'b1;
          end
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_shift = out_shift_q;
  assign out_zero  = out_zero_q;

endmodule : lzc_normalize_sequencer

// File: tb/tb_lzc_normalize_sequencer.sv
// Directed bench for lzc_normalize_sequencer: a driver pushes the hand-computed
// result for each accepted mantissa into a scoreboard queue, and an independent
// monitor checks values and latency whenever out_valid is seen.
module tb_lzc_normalize_sequencer;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  shift;
    logic        zero;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_shift;
  logic        out_zero;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;
  exp_t sb_q[$];

  lzc_normalize_sequencer #(.ZERO_SHIFT(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  // Posedge counter; an accept at edge N followed by out_valid after edge N+2
  // is a latency of 3 cycles counting the accept edge itself.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one mantissa once the block is idle; optionally record its expected result.
  task automatic send(input logic [31:0] d, input logic [31:0] e_data, input logic [5:0] e_shift,
                      input logic e_zero, input int e_lat, input bit track);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    if (track) sb_q.push_back('{data: e_data, shift: e_shift, zero: e_zero, lat: e_lat, acc: cyc + 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Monitor: checks each result when it first appears, retires it on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got out_data=0x%08h with no accepted input (t=%0t)", out_data, $time);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency",   32'(cyc - sb_q[0].acc + 1), 32'(sb_q[0].lat));
          check("out_data",  out_data, sb_q[0].data);
          check("out_shift", {26'd0, out_shift}, {26'd0, sb_q[0].shift});
          check("out_zero",  {31'd0, out_zero}, {31'd0, sb_q[0].zero});
        end
        if (out_ready) begin
          void'(sb_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_out_shift", {26'd0, out_shift}, 32'd0);
    check("rst_out_zero",  {31'd0, out_zero}, 32'd0);
    rst = 1'b0;

    // Basic vectors, consumer always ready.
    send(32'h8000_0000, 32'h8000_0000, 6'd0,  1'b0, 3, 1'b1);
    send(32'h0001_0000, 32'h8000_0000, 6'd15, 1'b0, 3, 1'b1);
    send(32'h0000_0001, 32'h8000_0000, 6'd31, 1'b0, 4, 1'b1);
    send(32'h0000_0000, 32'h0000_0000, 6'd32, 1'b1, 4, 1'b1);
    send(32'h1234_5678, 32'h91A2_B3C0, 6'd3,  1'b0, 3, 1'b1);
    send(32'h0000_0300, 32'hC000_0000, 6'd22, 1'b0, 4, 1'b1);

    // Back-pressure: result must hold while the consumer stalls.
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    out_ready = 1'b0;
    send(32'h00F0_0000, 32'hF000_0000, 6'd8, 1'b0, 3, 1'b1);
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("hold_out_valid_seen", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_out_shift", {26'd0, out_shift}, 32'd8);
      check("hold_out_data",  out_data, 32'hF000_0000);
      check("hold_in_ready",  {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset while the zero mantissa sits in CHK: result must be discarded.
    send(32'h0000_0000, 32'h0000_0000, 6'd32, 1'b1, 4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_zero",  {31'd0, out_zero}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_pulse", {31'd0, out_valid}, 32'd0);
    end
    send(32'h0000_8000, 32'h8000_0000, 6'd16, 1'b0, 4, 1'b1);

    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_lzc_normalize_sequencer

// File: doc/lzc_normalize_sequencer.md
Name: lzc_normalize_sequencer

Overview:
- Normalizes a 32-bit unsigned mantissa: left-shifts it until the MSB is 1, and reports the shift count and a zero flag.
- Time-shares one existing `sixteen_bit_lzc` instance (registered, 1-cycle latency) across the upper and lower halves, sequenced by a small FSM.
- Sits between the path-tracer arithmetic producers (fixed-to-float conversion, post-add renormalization) and the float packer.
- Uses a valid/ready handshake on both sides.

Parameters:
- ZERO_SHIFT, 32, value driven on out_shift when the input is all zeros (must fit in 6 bits).

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a mantissa on in_data
- in_ready  output  1  block can accept; high only in IDLE
- in_data  input  32  unsigned mantissa to normalize
- out_valid  output  1  result held on out_* until accepted
- out_ready  input  1  consumer accepts the result
- out_data  output  32  in_data << out_shift (0 when zero)
- out_shift  output  6  leading-zero count, 0..31, or ZERO_SHIFT
- out_zero  output  1  input was all zeros

Behaviour:
- Reset (rst high at a posedge): state=IDLE, out_valid=0, out_data=0, out_shift=0, out_zero=0, internal data_r=0.
  - in_ready is combinational (state==IDLE), so it reads 1 immediately after reset.
  - The LZC output register has no reset. Its value is never consumed until a HI cycle has refreshed it.
- LZC input mux: lzc.array = data_r[31:16] in state HI, data_r[15:0] in all other states.
- Zero detection is done by the controller with an OR-reduce on each half, never inferred from lzc.value. The LZC reports 15 for an all-zero 16-bit input.
- State IDLE:
  - in_ready=1.
  - On in_valid: data_r<=in_data, go to HI.
- State HI:
  - Upper half is driven into the LZC. Go to CHK.
- State CHK:
  - lzc.value now holds the upper-half count.
  - If data_r[31:16]!=0: out_shift<=value, out_data<=data_r<<value, out_zero<=0, out_valid<=1, go to OUT.
  - Else: go to LO. The lower half is driven into the LZC this cycle.
- State LO:
  - lzc.value holds the lower-half count.
  - If data_r[15:0]!=0: out_shift<=16+value, out_data<=data_r<<(16+value), out_zero<=0.
  - Else: out_shift<=ZERO_SHIFT, out_data<=0, out_zero<=1.
  - In both cases out_valid<=1, go to OUT.
- State OUT:
  - out_* held stable while out_ready=0.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready=0 throughout (no overlap in this revision).
- Latency, from the accept edge to out_valid high:
  - 3 cycles when the upper half is nonzero.
  - 4 cycles when the upper half is zero.
- Throughput: one result per 4 or 5 cycles with out_ready tied high.
- Arithmetic: shift amount is a 6-bit unsigned value. The shift is a combinational barrel shift of data_r, registered into out_data. Bits shifted past bit 31 are discarded (they are always zero by construction).
- Reset mid-operation in any state: the next cycle is in IDLE with all outputs at reset values. Any in-flight value is discarded, and no out_valid pulse follows.
- rst has priority over any handshake in the same cycle.
- out_valid never asserts without a preceding accept.

Decomposition:
- Package lzc_norm_pkg:
  - State enum (IDLE, HI, CHK, LO, OUT) as a 3-bit typedef.
  - Localparam HALF_W=16.
  - Localparam SHIFT_W=6.
- Sub-module: one instance of the existing `sixteen_bit_lzc`, with clk shared. No new sub-module is required.
- The barrel shifter is inline in the sequencer.

Test Plan:
- Accept 0x8000_0000 -> 3 cycles later out_valid=1, out_shift=0, out_data=0x8000_0000, out_zero=0.
- Accept 0x0001_0000 -> 3 cycles later out_shift=15, out_data=0x8000_0000.
- Accept 0x0000_0001 -> 4 cycles later out_shift=31, out_data=0x8000_0000.
- Accept 0x0000_0000 -> 4 cycles later out_zero=1, out_shift=32, out_data=0. This checks that the LZC's 15-on-zero is not leaked.
- Accept 0x00F0_0000 with out_ready held low for 5 cycles after out_valid:
  - out_shift=8 and out_data=0xF000_0000, stable throughout; in_ready=0 throughout.
  - Raise out_ready -> next cycle in_ready=1.
- Assert rst in CHK while processing 0x0000_0000:
  - Next cycle in_ready=1, out_valid=0, and no result pulse follows.
  - Then accept 0x0000_8000 -> 4 cycles later out_shift=16, out_data=0x8000_0000.
